text_buf_ctrl: RTL and testbench

Owns the 16×16 on-screen character buffer that feeds the character overlay pipeline. It serves the draw path's `char_xy` lookups every cycle and arbitrates buffer writes between two game-logic requesters (A: score/HUD updater, B: message writer) using round-robin. It also runs a full-buffer clear sequence on request and automatically after reset. It sits between the game logic and the font ROM: `char_code` from this block plus `char_line` from the draw path form the font ROM address.

---
 rtl/text_buf_ctrl.sv | 154 +++++++++++++++
 tb/tb_text_buf_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buf_ctrl.sv
// text_buf_ctrl: 16x16 on-screen character buffer.
// One registered read port serves the draw path every cycle. One write port
// is shared by two game-logic requesters (round-robin) and a clear sequencer
// that fills every cell with CLEAR_CODE after reset or on request.
module text_buf_ctrl #(
  parameter int unsigned       CODE_W      = 7,
  parameter logic [CODE_W-1:0] CLEAR_CODE  = 7'h20,
  parameter bit                VBLANK_ONLY = 1'b0
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vblnk,
  input  logic [7:0]        char_xy,
  output logic [CODE_W-1:0] char_code,
  input  logic              req_a,
  input  logic [7:0]        addr_a,
  input  logic [CODE_W-1:0] data_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic [7:0]        addr_b,
  input  logic [CODE_W-1:0] data_b,
  output logic              ack_b,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACK} state_t;

  logic [CODE_W-1:0] r_mem [256];
  logic [CODE_W-1:0] r_char_code;

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic              r_last_b, w_last_b_nxt;   // 1: B holds the most recent grant
  logic              r_ack_a, w_ack_a_nxt;
  logic              r_ack_b, w_ack_b_nxt;
  logic              r_clr_busy, w_clr_busy_nxt;
  logic              r_clr_done, w_clr_done_nxt;

  logic              w_we;
  logic [7:0]        w_waddr;
  logic [CODE_W-1:0] w_wdata;
  logic              w_wr_ok;
  logic              w_pick_a;
  logic              w_pick_b;

  // Requester writes may be restricted to vertical blanking.
  assign w_wr_ok  = !VBLANK_ONLY || vblnk;
  // A wins when alone, or on a tie when B was granted last; otherwise B.
  assign w_pick_a = req_a && (!req_b || r_last_b);
  assign w_pick_b = req_b && !w_pick_a;

  // Next-state, write-port steering and next output values.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_last_b_nxt   = r_last_b;
    w_ack_a_nxt    = 1'b0;
    w_ack_b_nxt    = 1'b0;
    w_clr_busy_nxt = r_clr_busy;
    w_clr_done_nxt = 1'b0;
    w_we           = 1'b0;
    w_waddr        = r_cnt;
    w_wdata        = CLEAR_CODE;

    case (r_state)
      S_CLEAR: begin
        // One cell per edge, no arbitration and no vblnk gating.
        w_we      = 1'b1;
        w_cnt_nxt = r_cnt + 8'd1;
        if (r_cnt == 8'hFF) begin
          w_state_nxt    = S_IDLE;
          w_clr_busy_nxt = 1'b0;
          w_clr_done_nxt = 1'b1;
        end
      end
      S_IDLE: begin
        if (clr_req) begin
          // Clear outranks pending writes; the first clear write is next edge.
          w_state_nxt    = S_CLEAR;
          w_cnt_nxt      = 8'd0;
          w_clr_busy_nxt = 1'b1;
        end else if (w_wr_ok && (req_a || req_b)) begin
          w_we         = 1'b1;
          w_waddr      = w_pick_a ? addr_a : addr_b;
          w_wdata      = w_pick_a ? data_a : data_b;
          w_ack_a_nxt  = w_pick_a;
          w_ack_b_nxt  = w_pick_b;
          w_last_b_nxt = w_pick_b;
          w_state_nxt  = S_ACK;
        end
      end
      S_ACK: begin
        // Requests are not sampled here, so a dropped req cannot re-grant.
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_CLEAR;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Control state and registered outputs; reset starts a clear at cell 0.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_CLEAR;
      r_cnt      <= 8'd0;
      r_last_b   <= 1'b1;
      r_ack_a    <= 1'b0;
      r_ack_b    <= 1'b0;
      r_clr_busy <= 1'b1;
      r_clr_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_last_b   <= w_last_b_nxt;
      r_ack_a    <= w_ack_a_nxt;
      r_ack_b    <= w_ack_b_nxt;
      r_clr_busy <= w_clr_busy_nxt;
      r_clr_done <= w_clr_done_nxt;
    end
  end

  // Buffer write port.
  // NOTE: the array has no reset; the clear sequence initialises it, and a
  // reset on the array would prevent mapping it onto block RAM.
  always_ff @(posedge pclk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Buffer read port: one-cycle latency, old data on a same-address write.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_char_code <= '0;
    end else begin
      r_char_code <= r_mem[char_xy];
    end
  end

  assign char_code = r_char_code;
  assign ack_a     = r_ack_a;
  assign ack_b     = r_ack_b;
  assign clr_busy  = r_clr_busy;
  assign clr_done  = r_clr_done;

endmodule

// File: tb/tb_text_buf_ctrl.sv
// Self-checking bench for text_buf_ctrl. A plain array models the buffer
// contents; expected timing comes from the cycle rules of the block.
// Two instances share inputs: dut (writes any time) and dut_v (vblank only).
`timescale 1ns/1ps
module tb_text_buf_ctrl;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       vblnk = 1'b0;
  logic [7:0] char_xy = 8'd0;
  logic       req_a = 1'b0, req_b = 1'b0, clr_req = 1'b0;
  logic [7:0] addr_a = 8'd0, addr_b = 8'd0;
  logic [6:0] data_a = 7'd0, data_b = 7'd0;

  logic [6:0] char_code, char_code_v;
  logic       ack_a, ack_b, clr_busy, clr_done;
  logic       ack_a_v, ack_b_v, clr_busy_v, clr_done_v;

  logic [6:0] model_mem [256];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 pclk = ~pclk;

  text_buf_ctrl dut (
    .pclk(pclk), .rst_n(rst_n), .vblnk(vblnk), .char_xy(char_xy), .char_code(char_code),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  text_buf_ctrl #(.VBLANK_ONLY(1'b1)) dut_v (
    .pclk(pclk), .rst_n(rst_n), .vblnk(vblnk), .char_xy(char_xy), .char_code(char_code_v),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a_v),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b_v),
    .clr_req(clr_req), .clr_busy(clr_busy_v), .clr_done(clr_done_v)
  );

  // Advance one edge and settle; inputs set afterwards apply to the next edge.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model_mem[i] = 7'h20;
  endtask

  // Wait for clr_done (bounded). edges = edges until it was seen.
  task automatic wait_clear(output int edges, output int early_idle, output int acks);
    edges = 0; early_idle = 0; acks = 0;
    while (edges < 400) begin
      tick();
      edges++;
      if (ack_a === 1'b1 || ack_b === 1'b1) acks++;
      if (clr_done === 1'b1) break;
      if (clr_busy !== 1'b1) early_idle++;
    end
  endtask

  // Pulse reset between edges and wait for the automatic clear to finish.
  task automatic apply_reset(output int edges);
    int early, acks;
    req_a = 1'b0; req_b = 1'b0; clr_req = 1'b0; vblnk = 1'b0;
    tick();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    wait_clear(edges, early, acks);
    model_clear();
    tick();
  endtask

  task automatic sweep_all(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      char_xy = 8'(i);
      tick();
      if (char_code !== model_mem[i]) begin
        bad++;
        if (bad <= 4) $display("FAIL %s cell %02h: got %02h, want %02h", tag, i, char_code, model_mem[i]);
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d cells wrong, want 0", tag, bad);
    end
  endtask

  task automatic test_reset();
    int edges, early, acks;
    #2 rst_n = 1'b0;
    #2;
    n_tests++;
    if (char_code !== 7'h00 || ack_a !== 1'b0 || ack_b !== 1'b0 || clr_busy !== 1'b1 || clr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: code=%h ack_a=%b ack_b=%b busy=%b done=%b, want 00 0 0 1 0",
               char_code, ack_a, ack_b, clr_busy, clr_done);
    end
    n_tests++;
    if (char_code_v !== 7'h00 || ack_a_v !== 1'b0 || ack_b_v !== 1'b0 || clr_busy_v !== 1'b1 || clr_done_v !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values_v: code=%h ack_a=%b ack_b=%b busy=%b done=%b, want 00 0 0 1 0",
               char_code_v, ack_a_v, ack_b_v, clr_busy_v, clr_done_v);
    end
    char_xy = 8'hFF;
    tick(); tick();
    rst_n = 1'b1;
    wait_clear(edges, early, acks);
    // Cells 0..255 are written on edges 0..255, done is visible after edge 255.
    n_tests++;
    if (edges != 256) begin n_fail++; $display("FAIL clear_len: got %0d edges, want 256", edges); end
    n_tests++;
    if (early != 0 || clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_busy: early idle %0d busy %b, want 0 and 0", early, clr_busy);
    end
    tick();
    n_tests++;
    if (clr_done !== 1'b0) begin n_fail++; $display("FAIL clear_done_pulse: got %b, want 0", clr_done); end
    model_clear();
  endtask

  task automatic test_single_write();
    req_a = 1'b1; addr_a = 8'h12; data_a = 7'h41;
    tick();
    n_tests++;
    if (ack_a !== 1'b1 || ack_b !== 1'b0) begin
      n_fail++; $display("FAIL single_ack: ack_a=%b ack_b=%b, want 1 0", ack_a, ack_b);
    end
    req_a = 1'b0;
    tick();
    n_tests++;
    if (ack_a !== 1'b0) begin n_fail++; $display("FAIL single_ack_width: ack_a=%b, want 0", ack_a); end
    model_mem[8'h12] = 7'h41;
    char_xy = 8'h12;
    tick();
    n_tests++;
    if (char_code !== 7'h41) begin n_fail++; $display("FAIL single_read: got %h, want 41", char_code); end
  endtask

  task automatic test_read_during_write();
    logic [6:0] old_v;
    old_v = model_mem[8'h34];
    char_xy = 8'h34;
    req_a = 1'b1; addr_a = 8'h34; data_a = 7'h55;
    tick();
    n_tests++;
    if (char_code !== old_v) begin n_fail++; $display("FAIL rdw_old: got %h, want %h", char_code, old_v); end
    req_a = 1'b0;
    model_mem[8'h34] = 7'h55;
    tick();
    n_tests++;
    if (char_code !== 7'h55) begin n_fail++; $display("FAIL rdw_new: got %h, want 55", char_code); end
  endtask

  task automatic test_random();
    int spurious = 0, timeouts = 0, rd_bad = 0;
    for (int it = 0; it < 200; it++) begin
      vblnk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        char_xy = 8'($urandom_range(0, 255));
        tick();
        n_tests++;
        if (char_code !== model_mem[char_xy]) begin
          n_fail++; rd_bad++;
          $display("FAIL rand_read %02h: got %h, want %h", char_xy, char_code, model_mem[char_xy]);
        end
      end else begin
        bit ra, rb, da, db;
        int t;
        ra = 1'($urandom_range(0, 1));
        rb = ra ? 1'($urandom_range(0, 1)) : 1'b1;
        addr_a = 8'($urandom_range(0, 255)); data_a = 7'($urandom_range(0, 127));
        addr_b = 8'($urandom_range(0, 255)); data_b = 7'($urandom_range(0, 127));
        req_a = ra; req_b = rb;
        da = !ra; db = !rb; t = 0;
        while (!(da && db) && t < 8) begin
          tick(); t++;
          if (ack_a === 1'b1) begin
            if (da) spurious++;
            else model_mem[addr_a] = data_a;
            req_a = 1'b0; da = 1'b1;
          end
          if (ack_b === 1'b1) begin
            if (db) spurious++;
            else model_mem[addr_b] = data_b;
            req_b = 1'b0; db = 1'b1;
          end
        end
        if (!(da && db)) timeouts++;
        req_a = 1'b0; req_b = 1'b0;
        tick();
      end
    end
    n_tests++;
    if (timeouts != 0) begin n_fail++; $display("FAIL rand_ack_timeout: %0d writes unacked, want 0", timeouts); end
    n_tests++;
    if (spurious != 0) begin n_fail++; $display("FAIL rand_spurious_ack: %0d, want 0", spurious); end
    vblnk = 1'b0;
    sweep_all("rand_sweep");
  endtask

  task automatic test_round_robin();
    int edges, k, both, worst, ta, tb;
    apply_reset(edges);
    n_tests++;
    if (edges != 256) begin n_fail++; $display("FAIL rr_reset_clear: got %0d edges, want 256", edges); end
    k = 0; both = 0; worst = 0; ta = -1; tb = -1;
    addr_a = 8'($urandom_range(0, 127));       data_a = 7'($urandom_range(0, 127));
    addr_b = 8'($urandom_range(128, 255));     data_b = 7'($urandom_range(0, 127));
    req_a = 1'b1; req_b = 1'b1;
    for (int t = 0; t < 40 && k < 8; t++) begin
      tick();
      if (ack_a === 1'b1 && ack_b === 1'b1) both++;
      if (ack_a === 1'b1) begin
        n_tests++;
        if (k % 2 != 0) begin n_fail++; $display("FAIL rr_order grant %0d: got A, want B", k); end
        if (t - ta > worst) worst = t - ta;
        model_mem[addr_a] = data_a; req_a = 1'b0; k++;
      end else if (req_a === 1'b0) begin
        addr_a = 8'($urandom_range(0, 127)); data_a = 7'($urandom_range(0, 127));
        req_a = 1'b1; ta = t;
      end
      if (ack_b === 1'b1) begin
        n_tests++;
        if (k % 2 != 1 && ack_a !== 1'b1) begin n_fail++; $display("FAIL rr_order grant %0d: got B, want A", k); end
        if (t - tb > worst) worst = t - tb;
        model_mem[addr_b] = data_b; req_b = 1'b0; k++;
      end else if (req_b === 1'b0) begin
        addr_b = 8'($urandom_range(128, 255)); data_b = 7'($urandom_range(0, 127));
        req_b = 1'b1; tb = t;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    tick(); tick();
    n_tests++;
    if (k != 8 || both != 0) begin n_fail++; $display("FAIL rr_count: grants %0d double %0d, want 8 and 0", k, both); end
    n_tests++;
    if (worst > 4) begin n_fail++; $display("FAIL rr_wait: worst %0d edges, want <= 4", worst); end
    sweep_all("rr_sweep");
  endtask

  task automatic test_vblank();
    int edges, acks;
    apply_reset(edges);
    n_tests++;
    if (clr_busy_v !== 1'b0) begin n_fail++; $display("FAIL vb_idle: busy_v=%b, want 0", clr_busy_v); end
    vblnk = 1'b0;
    req_b = 1'b1; addr_b = 8'h9C; data_b = 7'h3E;
    acks = 0;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (ack_b_v === 1'b1 || ack_a_v === 1'b1) acks++;
    end
    n_tests++;
    if (acks != 0) begin n_fail++; $display("FAIL vb_block: %0d acks in active video, want 0", acks); end
    // vblnk set after edge e is sampled at edge e+1; ack is visible after that edge.
    vblnk = 1'b1;
    tick();
    n_tests++;
    if (ack_b_v !== 1'b1) begin n_fail++; $display("FAIL vb_ack: ack_b_v=%b, want 1", ack_b_v); end
    req_b = 1'b0;
    tick();
    n_tests++;
    if (ack_b_v !== 1'b0) begin n_fail++; $display("FAIL vb_ack_width: ack_b_v=%b, want 0", ack_b_v); end
    char_xy = 8'h9C;
    tick();
    n_tests++;
    if (char_code_v !== 7'h3E) begin n_fail++; $display("FAIL vb_read: got %h, want 3e", char_code_v); end
    model_mem[8'h9C] = 7'h3E;   // dut wrote the same cell without vblank gating
    vblnk = 1'b0;
    tick();
  endtask

  task automatic test_clear_priority();
    int edges, early, acks;
    logic [7:0] a;
    logic [6:0] d;
    a = 8'($urandom_range(0, 255));
    d = 7'($urandom_range(64, 127));      // never the blank code
    tick();
    clr_req = 1'b1; req_a = 1'b1; addr_a = a; data_a = d;
    tick();
    n_tests++;
    if (clr_busy !== 1'b1 || ack_a !== 1'b0) begin
      n_fail++; $display("FAIL prio_start: busy=%b ack_a=%b, want 1 0", clr_busy, ack_a);
    end
    clr_req = 1'b0;
    wait_clear(edges, early, acks);
    n_tests++;
    if (edges != 256 || acks != 0) begin
      n_fail++; $display("FAIL prio_clear: edges %0d acks %0d, want 256 and 0", edges, acks);
    end
    tick();
    n_tests++;
    if (ack_a !== 1'b1) begin n_fail++; $display("FAIL prio_ack: ack_a=%b, want 1", ack_a); end
    req_a = 1'b0;
    model_clear();
    model_mem[a] = d;
    char_xy = a;
    tick();
    n_tests++;
    if (char_code !== d) begin n_fail++; $display("FAIL prio_cell: got %h, want %h", char_code, d); end
  endtask

  task automatic test_reset_mid_clear();
    int edges, early, acks;
    tick();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    char_xy = 8'h00;
    for (int t = 0; t < 100; t++) tick();
    n_tests++;
    if (char_code !== 7'h20 || clr_busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: code=%h busy=%b, want 20 1", char_code, clr_busy);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (char_code !== 7'h00 || clr_busy !== 1'b1 || clr_done !== 1'b0 || ack_a !== 1'b0 || ack_b !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: code=%h busy=%b done=%b ack=%b%b, want 00 1 0 00",
                         char_code, clr_busy, clr_done, ack_a, ack_b);
    end
    tick();
    rst_n = 1'b1;
    wait_clear(edges, early, acks);
    n_tests++;
    if (edges != 256) begin n_fail++; $display("FAIL mid_clear_len: got %0d edges, want 256", edges); end
    model_clear();
    tick();
    sweep_all("mid_sweep");
  endtask

  initial begin
    test_reset();
    sweep_all("clear_sweep");
    test_single_write();
    test_read_during_write();
    test_random();
    test_round_robin();
    test_vblank();
    test_clear_priority();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
